// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits for an in-order issue pipeline.
// Writeback lands on the falling edge (NEG_WR=1) or on the rising edge with a read bypass (NEG_WR=0).
module regfile_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NEG_WR  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              flush,
  output logic              hazard1,
  output logic              hazard2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;
  logic              wr_ok;
  logic              issue_ok;
  logic              set_new;
  logic              clr_old;

  // Index 0 is hardwired in ZERO_R0 mode: no writes, no pending bit.
  assign wr_ok    = wb_en && !(ZERO_R0 != 0 && wb_dest == '0);
  assign issue_ok = issue_en && !(ZERO_R0 != 0 && issue_dest == '0);

  if (NEG_WR != 0) begin : g_neg_wr
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NREGS; i++) mem[i] <= DATA_W'(i);
      end else if (wr_ok) begin
        mem[wb_dest] <= wb_data;
      end
    end
  end else begin : g_pos_wr
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NREGS; i++) mem[i] <= DATA_W'(i);
      end else if (wr_ok) begin
        mem[wb_dest] <= wb_data;
      end
    end
  end

  always_comb begin
    reg1 = mem[src1];
    if (NEG_WR == 0 && wr_ok && wb_dest == src1) reg1 = wb_data;
    if (ZERO_R0 != 0 && src1 == '0) reg1 = '0;
    reg2 = mem[src2];
    if (NEG_WR == 0 && wr_ok && wb_dest == src2) reg2 = wb_data;
    if (ZERO_R0 != 0 && src2 == '0) reg2 = '0;
  end

  // A writeback in flight means the operand is already readable (bypass or falling-edge write).
  assign hazard1 = pending[src1] && !(wb_en && wb_dest == src1);
  assign hazard2 = pending[src2] && !(wb_en && wb_dest == src2);

  // Issue beats writeback on a shared index, so a same-index clear never counts down.
  assign set_new = issue_ok && !pending[issue_dest];
  assign clr_old = wb_en && pending[wb_dest] && !(issue_ok && issue_dest == wb_dest);

  always_comb begin
    pending_nxt = pending;
    if (wb_en)    pending_nxt[wb_dest]    = 1'b0;
    if (issue_ok) pending_nxt[issue_dest] = 1'b1;
    if (flush)    pending_nxt             = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (flush)                    pend_cnt <= '0;
      else if (set_new && !clr_old) pend_cnt <= pend_cnt + CNT_ONE;
      else if (clr_old && !set_new) pend_cnt <= pend_cnt - CNT_ONE;
    end
  end

endmodule
